// File: rtl/cf_fft_pkg.sv
// Shared types and constants for the FFT operand-select sequencer.
// Holds the controller state enum, the four mux select codes and size defaults.
package cf_fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [2:0] SEL_OP1 = 3'b000;
    localparam logic [2:0] SEL_OP2 = 3'b101;
    localparam logic [2:0] SEL_OP3 = 3'b011;
    localparam logic [2:0] SEL_OP4 = 3'b001;

    localparam int N_LOG2_DEF   = 10;
    localparam int N_STAGES_DEF = 10;
    localparam int STAGE_W      = 4;
    localparam int FLUSH_W      = 8;

    // Phase 0..3 walks the operands 1,2,3,4 in order.
    function automatic logic [2:0] phase_to_sel(input logic [1:0] phase);
        logic [2:0] sel;
        case (phase)
            2'd0:    sel = SEL_OP1;
            2'd1:    sel = SEL_OP2;
            2'd2:    sel = SEL_OP3;
            default: sel = SEL_OP4;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cf_fft_1024_8_sel_ctrl_if.sv
// Control bundle between the frame sync/enable source and the select sequencer.
// The controller uses the slave modport; the upstream driver uses master.
interface cf_fft_1024_8_sel_ctrl_if #(
    parameter int N_LOG2 = 10
);
    // No valid/ready pair here: enable_i qualifies every edge, and sync_i is
    // only a request on edges where enable_i=1. Outputs are registered and
    // only change on enabled edges (or on reset).
    logic              enable_i;
    logic              sync_i;
    logic [2:0]        sel_o;
    logic [3:0]        stage_o;
    logic [N_LOG2-1:0] index_o;
    logic              busy_o;
    logic              sync_o;
    logic              err_o;
    logic [1:0]        dbg_state_o;

    modport master (
        output enable_i, sync_i,
        input  sel_o, stage_o, index_o, busy_o, sync_o, err_o, dbg_state_o
    );

    modport slave (
        input  enable_i, sync_i,
        output sel_o, stage_o, index_o, busy_o, sync_o, err_o, dbg_state_o
    );
endinterface

// File: rtl/cf_fft_sel_decode.sv
// Phase-to-select-code mapping for the 4-way operand mux.
// With CF_FFT_SEL_ROTATE_EN defined the phase is offset by the stage number.
module cf_fft_sel_decode
    import cf_fft_pkg::*;
(
    input  logic [1:0] i_index_lo,
`ifdef CF_FFT_SEL_ROTATE_EN
    input  logic [1:0] i_stage_lo,
`endif
    input  logic       i_run,
    output logic [2:0] o_sel
);

    logic [1:0] w_phase;

    always_comb begin
`ifdef CF_FFT_SEL_ROTATE_EN
        w_phase = i_index_lo + i_stage_lo;
`else
        w_phase = i_index_lo;
`endif
        o_sel = i_run ? phase_to_sel(w_phase) : SEL_OP1;
    end

endmodule

// File: rtl/cf_fft_1024_8_sel_ctrl.sv
// Frame sequencer for the FFT operand-select mux: IDLE -> RUN (all stages) -> FLUSH.
// Optional per-stage operand rotation is enabled by defining CF_FFT_SEL_ROTATE_EN.
module cf_fft_1024_8_sel_ctrl
    import cf_fft_pkg::*;
#(
    parameter int N_LOG2       = N_LOG2_DEF,
    parameter int N_STAGES     = N_STAGES_DEF,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                      clock_c,
    input  logic                      reset_i,
    cf_fft_1024_8_sel_ctrl_if.slave   bus
);

    localparam logic [N_LOG2-1:0]  IDX_MAX    = '1;
    localparam logic [STAGE_W-1:0] STG_LAST   = STAGE_W'(N_STAGES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);

    state_e              r_state;
    logic [N_LOG2-1:0]   r_index;
    logic [STAGE_W-1:0]  r_stage;
    logic [FLUSH_W-1:0]  r_flush;
    logic [2:0]          r_sel;
    logic                r_busy;
    logic                r_sync;
    logic                r_err;

    state_e              w_nxt_state;
    logic [N_LOG2-1:0]   w_nxt_index;
    logic [STAGE_W-1:0]  w_nxt_stage;
    logic [FLUSH_W-1:0]  w_nxt_flush;
    logic                w_frame_end;
    logic                w_err_evt;
    logic [2:0]          w_sel;

    // Next-state values are computed once so the select code can be decoded
    // from the upcoming index/stage and registered alongside them.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_index = r_index;
        w_nxt_stage = r_stage;
        w_nxt_flush = r_flush;
        w_frame_end = 1'b0;
        w_err_evt   = bus.sync_i && (r_state != IDLE);

        case (r_state)
            RUN: begin
                if (r_index == IDX_MAX) begin
                    w_nxt_index = '0;
                    if (r_stage == STG_LAST) begin
                        w_nxt_state = FLUSH;
                        w_nxt_flush = FLUSH_INIT;
                    end else begin
                        w_nxt_stage = r_stage + STAGE_W'(1);
                    end
                end else begin
                    w_nxt_index = r_index + N_LOG2'(1);
                end
            end
            FLUSH: begin
                if (r_flush == '0) begin
                    w_nxt_state = IDLE;
                    w_frame_end = 1'b1;
                end else begin
                    w_nxt_flush = r_flush - FLUSH_W'(1);
                end
            end
            default: ;
        endcase

        // A restart wins over every other transition, but the end-of-frame
        // pulse computed above still stands when both land on the same edge.
        if (bus.sync_i) begin
            w_nxt_state = RUN;
            w_nxt_index = '0;
            w_nxt_stage = '0;
            w_nxt_flush = '0;
        end
    end

    cf_fft_sel_decode u_sel_decode (
        .i_index_lo (w_nxt_index[1:0]),
`ifdef CF_FFT_SEL_ROTATE_EN
        .i_stage_lo (w_nxt_stage[1:0]),
`endif
        .i_run      (w_nxt_state == RUN),
        .o_sel      (w_sel)
    );

    always_ff @(posedge clock_c or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_index <= '0;
            r_stage <= '0;
            r_flush <= '0;
            r_sel   <= SEL_OP1;
            r_busy  <= 1'b0;
            r_sync  <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.enable_i) begin
            r_state <= w_nxt_state;
            r_index <= w_nxt_index;
            r_stage <= w_nxt_stage;
            r_flush <= w_nxt_flush;
            r_sel   <= w_sel;
            r_busy  <= (w_nxt_state != IDLE);
            r_sync  <= w_frame_end;
            r_err   <= w_err_evt;
        end
    end

    assign bus.sel_o       = r_sel;
    assign bus.stage_o     = r_stage;
    assign bus.index_o     = r_index;
    assign bus.busy_o      = r_busy;
    assign bus.sync_o      = r_sync;
    assign bus.err_o       = r_err;
    assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_cf_fft_1024_8_sel_ctrl.sv
// Self-checking bench for cf_fft_1024_8_sel_ctrl against a frame-position model.
// Honours CF_FFT_SEL_ROTATE_EN when the same macro is defined for the bench.
module tb_cf_fft_1024_8_sel_ctrl;

    localparam int N_LOG2   = 10;
    localparam int N_STAGES = 10;
    localparam int FLUSH    = 8;
    localparam int SAMPLES  = 1 << N_LOG2;
    localparam int RUN_LEN  = N_STAGES * SAMPLES;
    localparam int TOTAL    = RUN_LEN + FLUSH;
    localparam int VW       = 3 + 4 + N_LOG2 + 3;

`ifdef CF_FFT_SEL_ROTATE_EN
    localparam logic [2:0] EXP_S1_I0 = 3'b101;
    localparam logic [2:0] EXP_S3_I1 = 3'b000;
`else
    localparam logic [2:0] EXP_S1_I0 = 3'b000;
    localparam logic [2:0] EXP_S3_I1 = 3'b101;
`endif

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cf_fft_1024_8_sel_ctrl_if #(.N_LOG2(N_LOG2)) bus ();

    cf_fft_1024_8_sel_ctrl #(
        .N_LOG2       (N_LOG2),
        .N_STAGES     (N_STAGES),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clock_c (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int total;
    int bad;
    logic [N_LOG2-1:0] exp_q[$];

    // Model: position t within the current frame (RUN for t<RUN_LEN, then FLUSH).
    bit m_active;
    int m_t;
    int m_stage;
    bit m_sync;
    bit m_err;

    function automatic void model_reset();
        m_active = 0; m_t = 0; m_stage = 0; m_sync = 0; m_err = 0;
    endfunction

    function automatic void model_edge(input bit sy);
        m_sync = m_active && (m_t + 1 == TOTAL);
        m_err  = m_active && sy;
        if (sy) begin
            m_active = 1; m_t = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == TOTAL) m_active = 0;
        end
        if (m_active) m_stage = (m_t < RUN_LEN) ? m_t / SAMPLES : N_STAGES - 1;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        bit run;
        int idx;
        int ph;
        logic [2:0] sel;
        logic [N_LOG2-1:0] idx_v;
        logic [3:0] stg_v;
        run = m_active && (m_t < RUN_LEN);
        idx = run ? m_t % SAMPLES : 0;
        ph  = idx % 4;
`ifdef CF_FFT_SEL_ROTATE_EN
        ph  = (ph + m_stage) % 4;
`endif
        case (ph)
            0: sel = 3'b000;
            1: sel = 3'b101;
            2: sel = 3'b011;
            default: sel = 3'b001;
        endcase
        if (!run) sel = 3'b000;
        idx_v = idx[N_LOG2-1:0];
        stg_v = m_stage[3:0];
        return {sel, stg_v, idx_v, m_active, m_sync, m_err};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.sel_o, bus.stage_o, bus.index_o, bus.busy_o, bus.sync_o, bus.err_o};
    endfunction

    task automatic drive_cycle(input bit en, input bit sy);
        bus.enable_i = en;
        bus.sync_i   = sy;
        @(posedge clk);
        if (en) model_edge(sy);
        #1;
    endtask

    task automatic apply_reset();
        bus.enable_i = 0;
        bus.sync_i   = 0;
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        bus.enable_i = 1;
        bus.sync_i   = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", obs_vec());
        end
        rst = 0;
        bus.sync_i = 0;
    endtask

    task automatic test_first_phases();
        logic [2:0] exp_sel[5];
        exp_sel = '{3'b000, 3'b101, 3'b011, 3'b001, 3'b000};
        apply_reset();
        drive_cycle(1, 1);
        total++;
        if (bus.busy_o !== 1'b1 || bus.index_o !== '0 || bus.stage_o !== 4'd0) begin
            bad++; $display("FAIL start_latency got busy=%b idx=%0d stg=%0d exp busy=1 idx=0 stg=0",
                            bus.busy_o, bus.index_o, bus.stage_o);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) drive_cycle(1, 0);
            total++;
            if (bus.sel_o !== exp_sel[c]) begin
                bad++; $display("FAIL phase_sel c=%0d got=%b exp=%b", c, bus.sel_o, exp_sel[c]);
            end
            total++;
            if (obs_vec() !== model_vec()) begin
                bad++; $display("FAIL phase_vec c=%0d got=%h exp=%h", c, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_full_frame();
        int sync_cnt = 0;
        int sync_at  = -1;
        int max_stage = 0;
        apply_reset();
        drive_cycle(1, 1);
        for (int c = 1; c <= TOTAL + 6; c++) begin
            drive_cycle(1, 0);
            total++;
            if (obs_vec() !== model_vec()) begin
                bad++; $display("FAIL frame_vec c=%0d got=%h exp=%h", c, obs_vec(), model_vec());
            end
            if (bus.busy_o === 1'b1 && int'(bus.stage_o) > max_stage) max_stage = int'(bus.stage_o);
            if (bus.sync_o === 1'b1) begin
                sync_cnt++; sync_at = c;
                total++;
                if (bus.busy_o !== 1'b0) begin
                    bad++; $display("FAIL frame_busy_at_sync got=%b exp=0", bus.busy_o);
                end
            end
        end
        total++;
        if (sync_cnt != 1 || sync_at != TOTAL) begin
            bad++; $display("FAIL frame_sync got cnt=%0d at=%0d exp cnt=1 at=%0d", sync_cnt, sync_at, TOTAL);
        end
        total++;
        if (max_stage != N_STAGES - 1) begin
            bad++; $display("FAIL frame_last_stage got=%0d exp=%0d", max_stage, N_STAGES - 1);
        end
    endtask

    task automatic test_enable_toggle();
        int sync_at = -1;
        logic [N_LOG2-1:0] e;
        apply_reset();
        exp_q.delete();
        for (int t = 0; t < RUN_LEN; t++) exp_q.push_back(N_LOG2'(t % SAMPLES));
        drive_cycle(1, 1);
        e = exp_q.pop_front();
        total++;
        if (bus.index_o !== e) begin
            bad++; $display("FAIL toggle_index first got=%0d exp=%0d", bus.index_o, e);
        end
        for (int i = 1; i <= 2 * TOTAL + 8; i++) begin
            drive_cycle(i % 2 == 0, 0);
            total++;
            if (obs_vec() !== model_vec()) begin
                bad++; $display("FAIL toggle_vec i=%0d got=%h exp=%h", i, obs_vec(), model_vec());
            end
            if (i % 2 == 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.index_o !== e) begin
                    bad++; $display("FAIL toggle_index i=%0d got=%0d exp=%0d", i, bus.index_o, e);
                end
            end
            if (bus.sync_o === 1'b1 && sync_at < 0) sync_at = i;
        end
        total++;
        if (sync_at != 2 * TOTAL || exp_q.size() != 0) begin
            bad++; $display("FAIL toggle_sync got at=%0d left=%0d exp at=%0d left=0",
                            sync_at, exp_q.size(), 2 * TOTAL);
        end
    endtask

    task automatic test_restart();
        apply_reset();
        drive_cycle(1, 1);
        for (int c = 0; c < 4 * SAMPLES + 500; c++) begin
            drive_cycle(1, 0);
            total++;
            if (obs_vec() !== model_vec()) begin
                bad++; $display("FAIL restart_pre_vec c=%0d got=%h exp=%h", c, obs_vec(), model_vec());
            end
        end
        total++;
        if (bus.stage_o !== 4'd4 || bus.index_o !== N_LOG2'(500)) begin
            bad++; $display("FAIL restart_position got stg=%0d idx=%0d exp stg=4 idx=500", bus.stage_o, bus.index_o);
        end
        drive_cycle(1, 1);
        total++;
        if (bus.stage_o !== 4'd0 || bus.index_o !== '0 || bus.err_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL restart_mid_run got stg=%0d idx=%0d err=%b busy=%b exp 0 0 1 1",
                            bus.stage_o, bus.index_o, bus.err_o, bus.busy_o);
        end
        drive_cycle(1, 0);
        total++;
        if (bus.err_o !== 1'b0) begin
            bad++; $display("FAIL restart_err_width got=%b exp=0", bus.err_o);
        end
        for (int c = 0; c < TOTAL - 2; c++) begin
            drive_cycle(1, 0);
            total++;
            if (obs_vec() !== model_vec()) begin
                bad++; $display("FAIL restart_post_vec c=%0d got=%h exp=%h", c, obs_vec(), model_vec());
            end
        end
        drive_cycle(1, 1);
        total++;
        if (bus.sync_o !== 1'b1 || bus.err_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.index_o !== '0) begin
            bad++; $display("FAIL restart_at_end got sync=%b err=%b busy=%b idx=%0d exp 1 1 1 0",
                            bus.sync_o, bus.err_o, bus.busy_o, bus.index_o);
        end
        total++;
        if (obs_vec() !== model_vec()) begin
            bad++; $display("FAIL restart_at_end_vec got=%h exp=%h", obs_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid_flush();
        int sync_cnt = 0;
        apply_reset();
        drive_cycle(1, 1);
        for (int c = 0; c < RUN_LEN + 2; c++) drive_cycle(1, 0);
        total++;
        if (bus.busy_o !== 1'b1 || bus.sel_o !== 3'b000 || bus.stage_o !== 4'(N_STAGES - 1)) begin
            bad++; $display("FAIL flush_state got busy=%b sel=%b stg=%0d exp 1 000 %0d",
                            bus.busy_o, bus.sel_o, bus.stage_o, N_STAGES - 1);
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++; $display("FAIL async_reset got=%h exp=0", obs_vec());
        end
        @(posedge clk);
        #1;
        rst = 0;
        for (int c = 0; c < 2 * FLUSH + 8; c++) begin
            drive_cycle(1, 0);
            if (bus.sync_o === 1'b1) sync_cnt++;
            total++;
            if (obs_vec() !== model_vec()) begin
                bad++; $display("FAIL post_reset_vec c=%0d got=%h exp=%h", c, obs_vec(), model_vec());
            end
        end
        total++;
        if (sync_cnt != 0) begin
            bad++; $display("FAIL post_reset_sync got=%0d exp=0", sync_cnt);
        end
    endtask

    task automatic test_rotation();
        apply_reset();
        drive_cycle(1, 1);
        for (int c = 0; c < SAMPLES; c++) drive_cycle(1, 0);
        total++;
        if (bus.stage_o !== 4'd1 || bus.index_o !== '0 || bus.sel_o !== EXP_S1_I0) begin
            bad++; $display("FAIL rot_s1_i0 got stg=%0d idx=%0d sel=%b exp 1 0 %b",
                            bus.stage_o, bus.index_o, bus.sel_o, EXP_S1_I0);
        end
        for (int c = 0; c < 2 * SAMPLES + 1; c++) drive_cycle(1, 0);
        total++;
        if (bus.stage_o !== 4'd3 || bus.index_o !== N_LOG2'(1) || bus.sel_o !== EXP_S3_I1) begin
            bad++; $display("FAIL rot_s3_i1 got stg=%0d idx=%0d sel=%b exp 3 1 %b",
                            bus.stage_o, bus.index_o, bus.sel_o, EXP_S3_I1);
        end
    endtask

    task automatic test_random();
        apply_reset();
        drive_cycle(1, 1);
        for (int c = 0; c < 3000; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
            total++;
            if (obs_vec() !== model_vec()) begin
                bad++; $display("FAIL random_vec c=%0d got=%h exp=%h", c, obs_vec(), model_vec());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1;
        bus.enable_i = 0;
        bus.sync_i   = 0;
        model_reset();
        test_reset();
        test_first_phases();
        test_full_frame();
        test_enable_toggle();
        test_restart();
        test_reset_mid_flush();
        test_rotation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cf_fft_1024_8_sel_ctrl.md
# cf_fft_1024_8_sel_ctrl

Sequencing controller for the 1024-point, 8-bit FFT core's 4-way operand select mux. This mux decodes a 3-bit code: 3'b001 selects operand 4, 3'b011 operand 3, 3'b101 operand 2, and any other value operand 1. On a start pulse, the controller steps through all 10 radix-2 stages of 1024 samples each and drives the registered select code, stage number and sample index. It then flushes the datapath pipeline and emits an output sync pulse. It sits between the top-level sync/enable inputs and the butterfly datapath.

## Interface
- N_LOG2, 10, log2 of transform size; the index counter is N_LOG2 bits wide.
- N_STAGES, 10, number of stages per frame.
- FLUSH_CYCLES, 8, number of enabled cycles after the last stage before sync_o asserts; legal range 1..255.
- clock_c  input  1  single clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- enable_i  input  1  global clock enable; when low, all state and outputs hold.
- sync_i  input  1  start-of-frame pulse, sampled only when enable_i=1.
- sel_o  output  3  mux select code: 3'b000, 3'b101, 3'b011 or 3'b001.
- stage_o  output  4  current stage, 0..N_STAGES-1.
- index_o  output  N_LOG2  current sample index within the stage.
- busy_o  output  1  high in RUN and FLUSH.
- sync_o  output  1  one-cycle end-of-frame pulse.
- err_o  output  1  one-cycle pulse when sync_i arrives during RUN or FLUSH.

## Operation
- States:
  - IDLE: waiting for sync_i.
  - RUN: stepping index and stage.
  - FLUSH: counting down FLUSH_CYCLES.
- All transitions and counter updates occur only on edges where enable_i=1.
- IDLE: on sync_i=1, go to RUN with index=0 and stage=0.
- RUN: index increments each cycle.
  - When index=2^N_LOG2-1, index wraps to 0 and stage increments.
  - When both index=2^N_LOG2-1 and stage=N_STAGES-1, go to FLUSH with flush counter=FLUSH_CYCLES-1.
- FLUSH: the counter decrements each cycle. At counter=0, go to IDLE and assert sync_o for exactly one cycle.
- Select decode uses phase = index[1:0] (see Configuration):
  - phase 0 → 3'b000
  - phase 1 → 3'b101
  - phase 2 → 3'b011
  - phase 3 → 3'b001
- sel_o, stage_o and index_o are registered and mutually consistent in every cycle.
- In IDLE and FLUSH, sel_o=3'b000, index_o=0, and stage_o holds its last value.
- Restart: sync_i=1 during RUN or FLUSH restarts RUN at index=0, stage=0, and pulses err_o in the same cycle that RUN restarts.
- Reset: asynchronously forces IDLE and zeroes all counters, even mid-frame. Reset values:
  - sel_o=0, stage_o=0, index_o=0, busy_o=0, sync_o=0, err_o=0.
- Pulse width: sync_o and err_o are one-cycle pulses. If enable_i drops while a pulse is high, the pulse holds until the next enabled edge clears it.

## Timing
- Latency: the first enabled edge with sync_i=1 produces busy_o=1, index_o=0, stage_o=0 and sel_o=3'b000 in the following cycle.
- RUN lasts exactly N_STAGES·2^N_LOG2 = 10240 enabled cycles.
- FLUSH lasts FLUSH_CYCLES enabled cycles. sync_o is high in the first IDLE cycle, at the same time busy_o falls.
- Start to sync_o: 10240 + FLUSH_CYCLES enabled cycles, counting from the first RUN cycle.
- Disabled cycles extend all durations one-for-one and never drop or duplicate an index.
- sync_i sampled in the same cycle as the FLUSH→IDLE transition: the restart takes priority. The block enters RUN, and sync_o and err_o both pulse.

## Configuration
- CF_FFT_SEL_ROTATE_EN
  - Defined: phase = index[1:0] + stage[1:0] (mod 4), so the operand order rotates per stage.
  - Undefined: phase = index[1:0], and stage_o has no effect on sel_o.
- Both builds have identical state, timing and port list.

## Structure
- Shared package cf_fft_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - the four select-code constants (SEL_OP1=3'b000, SEL_OP2=3'b101, SEL_OP3=3'b011, SEL_OP4=3'b001);
  - the N_LOG2 and N_STAGES defaults.
- One natural sub-module, cf_fft_sel_decode: a combinational mapping from phase to select code, containing the optional rotation.

## Test plan
- Reset, then a sync_i pulse with enable_i=1 → the next cycle shows busy_o=1, index_o=0, sel_o=000. Cycles 1, 2 and 3 show sel_o=101, 011, 001, and cycle 4 returns to sel_o=000.
- Full frame with FLUSH_CYCLES=8 → stage_o steps 0..9; sync_o pulses exactly once, 10248 cycles after RUN entry; busy_o falls in the same cycle.
- enable_i toggling 1/0 every cycle → sync_o arrives after 2×10248 cycles, and the index sequence has no gaps or repeats.
- sync_i at stage 4, index 500 → the next cycle shows stage_o=0, index_o=0 and err_o=1 for one cycle, and the frame completes normally afterwards.
- reset_i asserted mid-FLUSH, between clock edges → all outputs go to 0 immediately, and no sync_o follows.
- With CF_FFT_SEL_ROTATE_EN defined, at stage 1, index 0 → sel_o=101; at stage 3, index 1 → sel_o=000.
